// File: rtl/sid_bus_master.sv
// Queued register-command initiator for the SID bus: commands are held in a FIFO and each one is
// issued as a single-clk strobe aligned to ce_1m. Read data comes back two clks after the strobe.
module sid_bus_master #(
    parameter int DUAL  = 1,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         ce_1m,
    input  logic                         flush,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic                         cmd_chip,
    input  logic                         cmd_rd,
    input  logic [4:0]                   cmd_addr,
    input  logic [7:0]                   cmd_data,
    input  logic [15:0]                  cmd_delay,
    output logic                         rsp_valid,
    output logic                         rsp_chip,
    output logic [7:0]                   rsp_data,
    output logic [(DUAL != 0 ? 1 : 0):0] cs,
    output logic                         we,
    output logic [4:0]                   addr,
    output logic [7:0]                   data_out,
    input  logic [7:0]                   data_in,
    output logic                         busy,
    output logic [$clog2(DEPTH):0]       fifo_level
);
    localparam int N  = (DUAL != 0) ? 2 : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [N-1:0] SEL_ONE = N'(1);

    typedef struct packed {
        logic        chip;
        logic        rd;
        logic [4:0]  addr;
        logic [7:0]  data;
        logic [15:0] delay;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STROBE,
        S_CAPTURE
    } state_t;

    cmd_t          mem_q [DEPTH];
    cmd_t          wr_entry;
    cmd_t          head;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          ready_q;
    logic          push;
    logic          pop;

    state_t        state_q;
    logic [15:0]   cnt_q;
    logic          cur_chip_q;
    logic          cur_rd_q;
    logic [4:0]    cur_addr_q;
    logic [7:0]    cur_data_q;

    logic [N-1:0]  cs_q;
    logic          we_q;
    logic [4:0]    addr_q;
    logic [7:0]    dout_q;
    logic          rsp_valid_q;
    logic          rsp_chip_q;
    logic [7:0]    rsp_data_q;

    always_comb begin
        cmd_ready = ready_q && !flush;
        push      = cmd_valid && cmd_ready;
        pop       = (state_q == S_IDLE) && (level_q != '0) && !flush;
        head      = mem_q[rd_ptr_q];

        wr_entry.chip  = (DUAL != 0) ? cmd_chip : 1'b0;
        wr_entry.rd    = cmd_rd;
        wr_entry.addr  = cmd_addr;
        wr_entry.data  = cmd_data;
        wr_entry.delay = cmd_delay;
    end

    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // Ready is registered from the next level, so a pop while full only reopens the port a clk later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            level_q <= level_d;
            ready_q <= (level_d != LW'(DEPTH));
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cur_chip_q  <= 1'b0;
            cur_rd_q    <= 1'b0;
            cur_addr_q  <= '0;
            cur_data_q  <= '0;
            cs_q        <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            dout_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_chip_q  <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            cs_q        <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            dout_q      <= '0;
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        cur_chip_q <= head.chip;
                        cur_rd_q   <= head.rd;
                        cur_addr_q <= head.addr;
                        cur_data_q <= head.data;
                        cnt_q      <= head.delay;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state_q <= S_IDLE;
                    end else if (ce_1m) begin
                        if (cnt_q == '0) begin
                            cs_q    <= SEL_ONE << cur_chip_q;
                            we_q    <= !cur_rd_q;
                            addr_q  <= cur_addr_q;
                            dout_q  <= cur_rd_q ? 8'h00 : cur_data_q;
                            state_q <= S_STROBE;
                        end else begin
                            cnt_q <= cnt_q - 16'd1;
                        end
                    end
                end
                S_STROBE: begin
                    state_q <= (cur_rd_q && !flush) ? S_CAPTURE : S_IDLE;
                end
                S_CAPTURE: begin
                    if (!flush) begin
                        rsp_valid_q <= 1'b1;
                        rsp_chip_q  <= cur_chip_q;
                        rsp_data_q  <= data_in;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        cs         = cs_q;
        we         = we_q;
        addr       = addr_q;
        data_out   = dout_q;
        rsp_valid  = rsp_valid_q;
        rsp_chip   = rsp_chip_q;
        rsp_data   = rsp_data_q;
        fifo_level = level_q;
        busy       = (level_q != '0) || (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_sid_bus_master.sv
// Bench for sid_bus_master: directed scenarios with literal expectations plus a randomized run,
// all cross-checked every cycle against a queue-based model of the command timing.
module tb_sid_bus_master;
    localparam int DEPTH     = 16;
    localparam int CE_PERIOD = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_1m = 1'b0;
    logic        flush = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_chip = 1'b0;
    logic        cmd_rd = 1'b0;
    logic [4:0]  cmd_addr = '0;
    logic [7:0]  cmd_data = '0;
    logic [15:0] cmd_delay = '0;
    logic [7:0]  data_in = '0;
    logic        cmd_ready, rsp_valid, rsp_chip, we, busy;
    logic [7:0]  rsp_data, data_out;
    logic [1:0]  cs;
    logic [4:0]  addr;
    logic [4:0]  fifo_level;

    logic        s_cmd_valid = 1'b0;
    logic        s_cmd_chip = 1'b0;
    logic        s_cmd_rd = 1'b0;
    logic [4:0]  s_cmd_addr = '0;
    logic [7:0]  s_data_in = 8'h5C;
    logic        s_cmd_ready, s_rsp_valid, s_rsp_chip, s_we, s_busy;
    logic [7:0]  s_rsp_data, s_data_out;
    logic [0:0]  s_cs;
    logic [4:0]  s_addr;
    logic [2:0]  s_fifo_level;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sid_bus_master #(.DUAL(1), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset_n(reset_n), .ce_1m(ce_1m), .flush(flush),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chip(cmd_chip), .cmd_rd(cmd_rd),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_delay(cmd_delay),
        .rsp_valid(rsp_valid), .rsp_chip(rsp_chip), .rsp_data(rsp_data),
        .cs(cs), .we(we), .addr(addr), .data_out(data_out), .data_in(data_in),
        .busy(busy), .fifo_level(fifo_level)
    );

    sid_bus_master #(.DUAL(0), .DEPTH(4)) u_dut_single (
        .clk(clk), .reset_n(reset_n), .ce_1m(ce_1m), .flush(1'b0),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_chip(s_cmd_chip), .cmd_rd(s_cmd_rd),
        .cmd_addr(s_cmd_addr), .cmd_data(8'h00), .cmd_delay(16'h0000),
        .rsp_valid(s_rsp_valid), .rsp_chip(s_rsp_chip), .rsp_data(s_rsp_data),
        .cs(s_cs), .we(s_we), .addr(s_addr), .data_out(s_data_out), .data_in(s_data_in),
        .busy(s_busy), .fifo_level(s_fifo_level)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a command queue plus the command currently being timed, counted in ce_1m ticks.
    typedef struct {
        bit       chip;
        bit       rd;
        bit [4:0] addr;
        bit [7:0] data;
        int       delay;
    } mcmd_t;

    mcmd_t    mq[$];
    mcmd_t    mcur;
    bit       m_wait, m_strobe, m_cap, m_rsp, m_rsp_chip;
    bit [7:0] m_rsp_data;
    int       m_ticks;

    always @(posedge clk) begin : model
        bit    idle_before;
        bit    accept;
        mcmd_t nc;
        if (!reset_n) begin
            mq.delete();
            m_wait = 0; m_strobe = 0; m_cap = 0; m_rsp = 0;
            m_rsp_chip = 0; m_rsp_data = 0; m_ticks = 0;
        end else begin
            idle_before = !m_wait && !m_strobe && !m_cap;
            accept = cmd_valid && (mq.size() < DEPTH) && !flush;
            m_rsp = 0;
            if (m_cap && !flush) begin
                m_rsp = 1;
                m_rsp_data = data_in;
                m_rsp_chip = mcur.chip;
            end
            m_cap = m_strobe && mcur.rd && !flush;
            m_strobe = 0;
            if (m_wait) begin
                if (flush) begin
                    m_wait = 0;
                end else if (ce_1m) begin
                    m_ticks++;
                    if (m_ticks == mcur.delay + 1) begin
                        m_wait = 0;
                        m_strobe = 1;
                    end
                end
            end
            if (idle_before && !flush && mq.size() > 0) begin
                mcur = mq.pop_front();
                m_wait = 1;
                m_ticks = 0;
            end
            if (flush) mq.delete();
            if (accept) begin
                nc.chip = cmd_chip; nc.rd = cmd_rd; nc.addr = cmd_addr;
                nc.data = cmd_data; nc.delay = int'(cmd_delay);
                mq.push_back(nc);
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [1:0] e_cs;
        if (chk_en && reset_n) begin
            e_cs = m_strobe ? (2'b01 << mcur.chip) : 2'b00;
            chk("cs", cs, e_cs);
            chk("we", we, m_strobe && !mcur.rd);
            chk("addr", addr, m_strobe ? mcur.addr : 5'd0);
            chk("data_out", data_out, (m_strobe && !mcur.rd) ? mcur.data : 8'd0);
            chk("rsp_valid", rsp_valid, m_rsp);
            if (m_rsp) begin
                chk("rsp_chip", rsp_chip, m_rsp_chip);
                chk("rsp_data", rsp_data, m_rsp_data);
            end
            chk("fifo_level", fifo_level, mq.size());
            chk("busy", busy, (mq.size() != 0) || m_wait || m_strobe || m_cap);
            chk("cmd_ready", cmd_ready, (mq.size() < DEPTH) && !flush);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input bit chip, input bit rd, input bit [4:0] a, input bit [7:0] d,
                        input bit [15:0] dly);
        cmd_valid = 1'b1; cmd_chip = chip; cmd_rd = rd;
        cmd_addr = a; cmd_data = d; cmd_delay = dly;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_write0(input bit chip, input bit [4:0] a, input bit [7:0] d);
        push(chip, 1'b0, a, d, 16'd0);
        tick();
        tick();
        chk("w0_no_early_strobe", cs, 2'b00);
        ce_1m = 1'b1;
        tick();
        ce_1m = 1'b0;
        chk("w0_cs", cs, chip ? 2'b10 : 2'b01);
        chk("w0_we", we, 1'b1);
        chk("w0_addr", addr, a);
        chk("w0_data", data_out, d);
        chk("w0_busy_during", busy, 1'b1);
        tick();
        chk("w0_cs_after", cs, 2'b00);
        chk("w0_busy_after", busy, 1'b0);
    endtask

    initial begin
        int st[2];
        int n;
        tick();
        tick();
        chk("rst_cs", cs, 2'b00);
        chk("rst_we", we, 1'b0);
        chk("rst_level", fifo_level, 5'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        reset_n = 1'b1;
        chk_en = 1'b1;
        tick();

        run_write0(1'b0, 5'h04, 8'h41);

        push(1'b0, 1'b0, 5'h07, 8'h33, 16'd3);
        tick();
        for (int p = 1; p <= 4; p++) begin
            ce_1m = 1'b1;
            tick();
            ce_1m = 1'b0;
            chk("delay3_strobe", cs, (p == 4) ? 2'b01 : 2'b00);
            tick();
            tick();
        end

        push(1'b0, 1'b0, 5'h05, 8'h11, 16'd0);
        push(1'b1, 1'b0, 5'h06, 8'h22, 16'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            ce_1m = (i % CE_PERIOD == 0);
            tick();
            if (cs != 2'b00) begin
                if (n < 2) st[n] = i;
                n++;
            end
        end
        ce_1m = 1'b0;
        chk("b2b_count", n, 2);
        if (n >= 2) chk("b2b_gap", st[1] - st[0], CE_PERIOD);

        data_in = 8'hA5;
        s_cmd_valid = 1'b1; s_cmd_chip = 1'b1; s_cmd_rd = 1'b1; s_cmd_addr = 5'h1B;
        push(1'b1, 1'b1, 5'h1B, 8'h00, 16'd0);
        s_cmd_valid = 1'b0;
        tick();
        ce_1m = 1'b1;
        tick();
        ce_1m = 1'b0;
        chk("rd_cs", cs, 2'b10);
        chk("rd_we", we, 1'b0);
        chk("rd_addr", addr, 5'h1B);
        chk("s_rd_cs", s_cs, 1'b1);
        chk("s_rd_we", s_we, 1'b0);
        tick();
        chk("rd_cs_off", cs, 2'b00);
        chk("rd_rsp_early", rsp_valid, 1'b0);
        tick();
        chk("rd_rsp_valid", rsp_valid, 1'b1);
        chk("rd_rsp_chip", rsp_chip, 1'b1);
        chk("rd_rsp_data", rsp_data, 8'hA5);
        chk("s_rsp_valid", s_rsp_valid, 1'b1);
        chk("s_rsp_chip", s_rsp_chip, 1'b0);
        chk("s_rsp_data", s_rsp_data, 8'h5C);
        tick();
        chk("rd_rsp_pulse", rsp_valid, 1'b0);

        for (int i = 0; i < 16; i++) push(1'b0, 1'b0, 5'(i), 8'(i), 16'd0);
        chk("bp_level15", fifo_level, 5'd15);
        push(1'b0, 1'b0, 5'h10, 8'hF0, 16'd0);
        chk("bp_level16", fifo_level, 5'd16);
        chk("bp_ready_full", cmd_ready, 1'b0);
        cmd_valid = 1'b1; cmd_addr = 5'h11; cmd_data = 8'hF1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold", fifo_level, 5'd16);
        end
        ce_1m = 1'b1;
        tick();
        ce_1m = 1'b0;
        tick();
        chk("bp_still_full", fifo_level, 5'd16);
        tick();
        chk("bp_after_pop", fifo_level, 5'd15);
        chk("bp_ready_again", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        chk("bp_18th_in", fifo_level, 5'd16);
        flush = 1'b1;
        tick();
        flush = 1'b0;

        for (int i = 0; i < 6; i++) push(1'b1, 1'b0, 5'(i + 8), 8'(i), 16'd1);
        chk("fl_level5", fifo_level, 5'd5);
        flush = 1'b1; ce_1m = 1'b1; cmd_valid = 1'b1;
        tick();
        flush = 1'b0; ce_1m = 1'b0; cmd_valid = 1'b0;
        chk("fl_level0", fifo_level, 5'd0);
        chk("fl_busy0", busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            ce_1m = 1'b1;
            tick();
            ce_1m = 1'b0;
            chk("fl_no_strobe", cs, 2'b00);
        end

        push(1'b0, 1'b1, 5'h0A, 8'h00, 16'd0);
        tick();
        ce_1m = 1'b1;
        tick();
        ce_1m = 1'b0;
        chk("fls_strobe", cs, 2'b01);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fls_cs_off", cs, 2'b00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fls_no_rsp", rsp_valid, 1'b0);
        end

        push(1'b1, 1'b0, 5'h12, 8'h77, 16'd0);
        tick();
        ce_1m = 1'b1;
        tick();
        ce_1m = 1'b0;
        chk("ar_strobe", cs, 2'b10);
        chk_en = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("ar_cs", cs, 2'b00);
        chk("ar_we", we, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        chk_en = 1'b1;
        chk("ar_ready", cmd_ready, 1'b1);
        chk("ar_level", fifo_level, 5'd0);
        run_write0(1'b1, 5'h18, 8'h9C);

        for (int i = 0; i < 3000; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_chip  = 1'($urandom);
            cmd_rd    = 1'($urandom);
            cmd_addr  = 5'($urandom);
            cmd_data  = 8'($urandom);
            cmd_delay = 16'($urandom_range(0, 3));
            ce_1m     = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 59) == 0);
            data_in   = 8'($urandom);
            tick();
        end
        cmd_valid = 1'b0; flush = 1'b0; ce_1m = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
